// File: rtl/ssd_pkg.sv
// Shared seven-segment constants: active-low hex glyphs {a,b,c,d,e,f,g}
// and display limits used by the scan driver and any other display logic.
package ssd_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

endpackage

// File: rtl/ssd_scan_driver_if.sv
// Display bus between status logic (master) and the scan driver (slave):
// per-digit data/attributes in, multiplexed anode/cathode pins out.
interface ssd_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);

  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [NUM_DIGITS-1:0]   blink_en;
  logic                    lz_blank;
  logic [3:0]              brightness;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;
  logic                    frame_pulse;

  modport master (
    output value, dp_in, digit_en, blink_en, lz_blank, brightness,
    input  an, seg, dp, frame_pulse
  );

  modport slave (
    input  value, dp_in, digit_en, blink_en, lz_blank, brightness,
    output an, seg, dp, frame_pulse
  );

endinterface

// File: rtl/ssd_hex_decoder.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_HEX[i_nibble];

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-synchronous shadow capture,
// leading-zero blanking, per-digit blink and 16-level PWM brightness.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int SCAN_DIV_BITS = 18,
  parameter int BLINK_BITS    = 5
) (
  input  logic             ClkPort,
  input  logic             Reset,
  ssd_scan_driver_if.slave bus
);

  localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [SCAN_DIV_BITS-1:0] r_presc_p0;
  logic [IDX_W-1:0]         r_idx_p0;
  logic [BLINK_BITS-1:0]    r_blink;

  logic [4*NUM_DIGITS-1:0]  r_sh_value;
  logic [NUM_DIGITS-1:0]    r_sh_dp;
  logic [NUM_DIGITS-1:0]    r_sh_digit_en;
  logic [NUM_DIGITS-1:0]    r_sh_blink_en;
  logic                     r_sh_lz;
  logic [3:0]               r_sh_bright;

  logic [NUM_DIGITS-1:0]    r_an_p1;
  logic [6:0]               r_seg_p1;
  logic                     r_dp_p1;
  logic                     r_frame_pulse_p1;

  logic                     w_slot_end;
  logic                     w_frame_end;
  logic [3:0]               w_nib;
  logic [6:0]               w_seg_dec;
  logic [NUM_DIGITS-1:0]    w_lz_hit;
  logic                     w_upper_zero;
  logic                     w_lit;
  logic [NUM_DIGITS-1:0]    w_an_sel;

  assign w_slot_end  = &r_presc_p0;
  assign w_frame_end = w_slot_end && (r_idx_p0 == LAST_IDX);

  // stage p0: scan counters and frame-synchronous shadow capture
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      r_presc_p0    <= '0;
      r_idx_p0      <= '0;
      r_blink       <= '0;
      r_sh_value    <= '0;
      r_sh_dp       <= '0;
      r_sh_digit_en <= '0;
      r_sh_blink_en <= '0;
      r_sh_lz       <= 1'b0;
      r_sh_bright   <= '0;
    end else begin
      r_presc_p0 <= r_presc_p0 + 1'b1;
      if (w_slot_end) begin
        r_idx_p0 <= (r_idx_p0 == LAST_IDX) ? '0 : r_idx_p0 + 1'b1;
      end
      if (w_frame_end) begin
        r_blink       <= r_blink + 1'b1;
        r_sh_value    <= bus.value;
        r_sh_dp       <= bus.dp_in;
        r_sh_digit_en <= bus.digit_en;
        r_sh_blink_en <= bus.blink_en;
        r_sh_lz       <= bus.lz_blank;
        r_sh_bright   <= bus.brightness;
      end
    end
  end

  // Scan from the top digit down; a digit is blanked while every nibble at or above it is zero.
  always_comb begin
    w_lz_hit     = '0;
    w_upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_upper_zero = w_upper_zero && (r_sh_value[4*k +: 4] == 4'h0);
      if (k > 0) begin
        w_lz_hit[k] = r_sh_lz && w_upper_zero;
      end
    end
  end

  assign w_nib = r_sh_value[{r_idx_p0, 2'b00} +: 4];

  ssd_hex_decoder u_dec (
    .i_nibble (w_nib),
    .o_seg    (w_seg_dec)
  );

  assign w_lit = r_sh_digit_en[r_idx_p0]
              && !(r_sh_blink_en[r_idx_p0] && r_blink[BLINK_BITS-1])
              && !w_lz_hit[r_idx_p0]
              && (r_presc_p0[SCAN_DIV_BITS-1 -: 4] <= r_sh_bright);

  assign w_an_sel = ~(NUM_DIGITS'(1) << r_idx_p0);

  // stage p1: registered pin drivers
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      r_an_p1          <= '1;
      r_seg_p1         <= SEG_BLANK;
      r_dp_p1          <= 1'b1;
      r_frame_pulse_p1 <= 1'b0;
    end else begin
      r_frame_pulse_p1 <= w_frame_end;
      if (w_lit) begin
        r_an_p1  <= w_an_sel;
        r_seg_p1 <= w_seg_dec;
        r_dp_p1  <= ~r_sh_dp[r_idx_p0];
      end else begin
        r_an_p1  <= '1;
        r_seg_p1 <= SEG_BLANK;
        r_dp_p1  <= 1'b1;
      end
    end
  end

  assign bus.an          = r_an_p1;
  assign bus.seg         = r_seg_p1;
  assign bus.dp          = r_dp_p1;
  assign bus.frame_pulse = r_frame_pulse_p1;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver with 4 digits, 16-cycle slots, 2-bit blink counter.
module tb_ssd_scan_driver;

  localparam logic [6:0] S_0 = 7'b0000001;
  localparam logic [6:0] S_1 = 7'b1001111;
  localparam logic [6:0] S_2 = 7'b0010010;
  localparam logic [6:0] S_5 = 7'b0100100;
  localparam logic [6:0] S_A = 7'b0001000;
  localparam logic [6:0] S_F = 7'b0111000;
  localparam logic [6:0] S_X = 7'h7F;

  logic ClkPort = 1'b0;
  logic Reset   = 1'b1;
  int   cyc     = 0;
  int   n_cmp   = 0;
  int   n_err   = 0;

  always #5 ClkPort = ~ClkPort;

  ssd_scan_driver_if #(.NUM_DIGITS(4)) bus ();

  ssd_scan_driver #(
    .NUM_DIGITS    (4),
    .SCAN_DIV_BITS (4),
    .BLINK_BITS    (2)
  ) dut (
    .ClkPort (ClkPort),
    .Reset   (Reset),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(negedge ClkPort);
      cyc++;
    end
  endtask

  initial begin
    logic [6:0] seg_f2 [4];
    logic [3:0] one;
    logic [3:0] exp_an;
    int         fp_at;

    seg_f2 = '{S_F, S_A, S_2, S_1};
    one    = 4'b0001;

    bus.value      = 16'h12AF;
    bus.dp_in      = 4'b0000;
    bus.digit_en   = 4'hF;
    bus.blink_en   = 4'b0000;
    bus.lz_blank   = 1'b0;
    bus.brightness = 4'd15;

    repeat (3) @(negedge ClkPort);
    check("rst_an", bus.an, 4'hF);
    check("rst_seg", bus.seg, S_X);
    check("rst_dp", bus.dp, 1'b1);
    check("rst_fp", bus.frame_pulse, 1'b0);
    Reset = 1'b0;
    cyc   = 0;

    // Frame 0: shadows still hold reset values, display blank
    for (int c = 1; c <= 64; c++) begin
      goto(c);
      check("f0_an", bus.an, 4'hF);
      check("f0_seg", bus.seg, S_X);
      if (c == 63) check("f0_fp_early", bus.frame_pulse, 1'b0);
    end
    check("first_fp", bus.frame_pulse, 1'b1);

    // Frame 1: 12AF, full brightness
    goto(65);
    check("f1_d0_an", bus.an, 4'b1110);
    check("f1_d0_seg", bus.seg, S_F);
    check("f1_d0_dp", bus.dp, 1'b1);
    check("f1_fp_low", bus.frame_pulse, 1'b0);
    goto(81);
    check("f1_d1_an", bus.an, 4'b1101);
    check("f1_d1_seg", bus.seg, S_A);
    goto(97);
    check("f1_d2_an", bus.an, 4'b1011);
    check("f1_d2_seg", bus.seg, S_2);
    goto(113);
    check("f1_d3_an", bus.an, 4'b0111);
    check("f1_d3_seg", bus.seg, S_1);
    bus.brightness = 4'd0;
    goto(128);
    check("f1_fp", bus.frame_pulse, 1'b1);

    // Frame 2: brightness 0 lights each digit only on presc 0
    for (int c = 129; c <= 192; c++) begin
      int p;
      int d;
      goto(c);
      p      = c - 1;
      d      = (p / 16) % 4;
      exp_an = ((p % 16) == 0) ? ~(one << d) : 4'hF;
      check("dim_an", bus.an, exp_an);
      check("dim_seg", bus.seg, ((p % 16) == 0) ? seg_f2[d] : S_X);
      if (c == 129) begin
        bus.value      = 16'h0050;
        bus.lz_blank   = 1'b1;
        bus.brightness = 4'd15;
      end
    end

    // Frame 3: leading-zero blanking of 0050
    goto(198);
    check("lz_d0_an", bus.an, 4'b1110);
    check("lz_d0_seg", bus.seg, S_0);
    goto(214);
    check("lz_d1_an", bus.an, 4'b1101);
    check("lz_d1_seg", bus.seg, S_5);
    goto(230);
    check("lz_d2_an", bus.an, 4'hF);
    check("lz_d2_seg", bus.seg, S_X);
    goto(246);
    check("lz_d3_an", bus.an, 4'hF);
    check("lz_d3_seg", bus.seg, S_X);
    bus.value    = 16'h1111;
    bus.lz_blank = 1'b0;

    // Frame 4: value changes mid-frame, display keeps the captured 1111
    goto(262);
    check("tear_d0_seg", bus.seg, S_1);
    goto(295);
    bus.value = 16'h2222;
    goto(300);
    check("tear_d2_an", bus.an, 4'b1011);
    check("tear_d2_seg", bus.seg, S_1);
    goto(310);
    check("tear_d3_an", bus.an, 4'b0111);
    check("tear_d3_seg", bus.seg, S_1);
    goto(320);
    check("tear_fp", bus.frame_pulse, 1'b1);

    // Frame 5: new value on every digit
    goto(325);
    check("new_d0_an", bus.an, 4'b1110);
    check("new_d0_seg", bus.seg, S_2);
    goto(341);
    check("new_d1_seg", bus.seg, S_2);
    goto(357);
    check("new_d2_seg", bus.seg, S_2);
    goto(373);
    check("new_d3_an", bus.an, 4'b0111);
    check("new_d3_seg", bus.seg, S_2);
    bus.blink_en = 4'b0001;
    bus.dp_in    = 4'b0010;

    // Frames 6/7 blink phase 1: digit 0 off; frame 8 phase 0: on
    goto(390);
    check("blk6_d0_an", bus.an, 4'hF);
    check("blk6_d0_seg", bus.seg, S_X);
    check("blk6_d0_dp", bus.dp, 1'b1);
    goto(406);
    check("blk6_d1_an", bus.an, 4'b1101);
    check("blk6_d1_seg", bus.seg, S_2);
    check("blk6_d1_dp", bus.dp, 1'b0);
    goto(454);
    check("blk7_d0_an", bus.an, 4'hF);
    goto(518);
    check("blk8_d0_an", bus.an, 4'b1110);
    check("blk8_d0_seg", bus.seg, S_2);
    check("blk8_d0_dp", bus.dp, 1'b1);
    goto(534);
    check("blk8_d1_dp", bus.dp, 1'b0);
    bus.digit_en = 4'b0111;

    // Frame 9: digit 3 disabled, blink phase 0 keeps digit 0 on
    goto(582);
    check("en9_d0_an", bus.an, 4'b1110);
    goto(614);
    check("en9_d2_an", bus.an, 4'b1011);
    goto(630);
    check("en9_d3_an", bus.an, 4'hF);
    check("en9_d3_seg", bus.seg, S_X);

    // Frame 10: asynchronous reset during the digit 2 slot
    goto(675);
    check("pre_rst_an", bus.an, 4'b1011);
    check("pre_rst_seg", bus.seg, S_2);
    #2 Reset = 1'b1;
    #1;
    check("async_an", bus.an, 4'hF);
    check("async_seg", bus.seg, S_X);
    check("async_dp", bus.dp, 1'b1);
    check("async_fp", bus.frame_pulse, 1'b0);
    repeat (3) @(negedge ClkPort);
    Reset = 1'b0;

    fp_at = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge ClkPort);
      if (n == 10) check("post_rst_blank", bus.an, 4'hF);
      if (bus.frame_pulse === 1'b1) begin
        fp_at = n;
        break;
      end
    end
    check("post_rst_fp_cycle", fp_at, 64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ssd_scan_driver.md
# ssd_scan_driver

Parametrised seven-segment scan driver for the Nexys4 display. It replaces the fixed 4-digit scan-and-decode logic in the top level with a reusable block that supports 1–8 digits and per-digit enable, blink and decimal point. It also adds leading-zero blanking, 16-level PWM brightness and tear-free frame-synchronous capture of display data. It sits between game/status logic and the An*/Ca..Cg/Dp pins.

## Interface
Parameters:
- NUM_DIGITS, 8, number of digits scanned (1..8).
- SCAN_DIV_BITS, 18, log2 of clock cycles per digit slot (≥4; 18 → 2.62 ms at 100 MHz).
- BLINK_BITS, 5, width of the frame counter; its MSB is the blink phase.

Ports:
- ClkPort  in  1  system clock, 100 MHz.
- Reset  in  1  asynchronous, active-high reset.
- value  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i, with digit 0 rightmost.
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- digit_en  in  NUM_DIGITS  1 = digit shown; 0 = digit forced blank.
- blink_en  in  NUM_DIGITS  1 = digit blanked while the blink phase is 1.
- lz_blank  in  1  leading-zero blanking enable.
- brightness  in  4  PWM level; 0 = 1/16 duty, 15 = full duty.
- an  out  NUM_DIGITS  anodes, active-low.
- seg  out  7  cathodes {a,b,c,d,e,f,g}, active-low.
- dp  out  1  decimal point cathode, active-low.
- frame_pulse  out  1  one-cycle pulse when the shadow registers load.

## Operation
- **presc**: SCAN_DIV_BITS-wide free-running counter.
- **idx**: digit index. It advances when presc is all-ones and wraps from NUM_DIGITS-1 to 0.
- **Shadow registers**: value, dp_in, digit_en, blink_en, lz_blank and brightness are copied into shadow registers on the cycle where presc is all-ones and idx = NUM_DIGITS-1. That same cycle increments the blink counter (wraps modulo 2^BLINK_BITS) and asserts frame_pulse. Input changes at any other time have no effect until the next frame.
- **Lit condition**: digit idx is lit only if all of the following hold:
  - shadow digit_en[idx] = 1;
  - not (blink_en[idx] and blink MSB = 1);
  - not LZ-blanked;
  - presc[SCAN_DIV_BITS-1 -: 4] ≤ shadow brightness.
- **Leading-zero blanking**: digit k is LZ-blanked when lz_blank = 1, k > 0, and nibbles k..NUM_DIGITS-1 are all zero. Digit 0 is never LZ-blanked.
- **Lit output**: an has a single 0 at bit idx. seg is the hex decode of nibble idx. dp = ~shadow dp_in[idx].
- **Unlit output**: an is all ones, seg = 7'h7F, dp = 1.
- **Hex decode** (abcdefg, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- **Reset values**: all counters and shadows are 0. an is all ones, seg = 7'h7F, dp = 1, frame_pulse = 0. Because shadow digit_en is 0, the display stays blank for the entire first frame after reset.

## Timing
- an, seg, dp and frame_pulse are registered. They reflect the presc/idx values of the previous cycle (1-cycle latency).
- Digit slot = 2^SCAN_DIV_BITS cycles. Frame = NUM_DIGITS slots.
- The first shadow load after reset occurs at cycle NUM_DIGITS·2^SCAN_DIV_BITS − 1. frame_pulse is high on the following cycle.
- Reset mid-scan forces all outputs to their reset values asynchronously. Scanning restarts at idx 0, presc 0.
- an and seg change on the same edge. No dead-time is inserted.

## Structure
- Package ssd_pkg holds:
  - the 16-entry active-low segment constants;
  - SEG_BLANK = 7'h7F;
  - MAX_DIGITS = 8.
- Sub-module ssd_hex_decoder: combinational 4-bit to 7-bit decode using ssd_pkg. It is shared with any other display logic.
- The top level instantiates ssd_scan_driver with NUM_DIGITS=8 and drives An0..An7 from an.

## Test plan
Unless a scenario states otherwise, all benches use NUM_DIGITS=4, SCAN_DIV_BITS=4, BLINK_BITS=2.

1. **Reset and first display**: hold value=16'h12AF, digit_en=4'hF, brightness=15, then release Reset.
   - → an=4'hF, seg=7'h7F for the first 64 cycles.
   - → next frame, digit 0 slot: an=1110, seg=0111000 (F). Digit 1 slot: an=1101, seg=0001000 (A).
2. **Minimum brightness**: brightness=0.
   - → each digit's anode is low for exactly 1 of its 16 slot cycles (presc=0).
   - → seg=7'h7F on the other 15 cycles.
3. **Leading-zero blanking**: value=16'h0050, lz_blank=1.
   - → digits 3 and 2 are blank.
   - → digit 1 shows seg=0100100 (5); digit 0 shows seg=0000001 (0).
4. **Tear-free capture**: change value from 16'h1111 to 16'h2222 during the digit 2 slot.
   - → digits 2 and 3 still show 1 this frame.
   - → 2 appears on all digits only from the frame after the next frame_pulse.
5. **Blink**: blink_en=4'b0001.
   - → digit 0 is lit in frames where the blink counter is 0 or 1, blank where it is 2 or 3.
   - → digits 1–3 are unaffected.
6. **Reset mid-scan**: assert Reset during the digit 2 slot.
   - → an=4'hF, seg=7'h7F, dp=1 in the same cycle (asynchronous).
   - → after release, the first frame_pulse arrives 64 cycles later.
